// File: rtl/multi_pulse_gen_pkg.sv
// Shared definitions for the multi-channel pulse generator.
//   state_e      : per-channel FSM state encoding (IDLE / HIGH / LOW)
//   MODE_CONT    : mode bit value for continuous (periodic) operation
//   MODE_ONESHOT : mode bit value for triggered one-shot operation
package multi_pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/multi_pulse_gen_pulse_ch.sv
// One pulse channel: FSM, down-counter, configuration latch and trigger
// edge detector.
//   clk, rst_n          : clock and asynchronous active-low reset
//   enable              : run enable; low forces IDLE on the next edge
//   mode                : 0 = continuous, 1 = one-shot (sampled at start only)
//   trigger             : one-shot trigger, rising-edge sensitive
//   period, width       : configuration, latched at start / period boundary
//   pulse_out, busy     : registered pulse and activity status
//   done                : one-cycle strobe when a one-shot pulse completes
//   cfg_err             : sticky, set when a start sees period == 0
module pulse_ch
    import multi_pulse_gen_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mode,
    input  logic             trigger,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // A width longer than the period degenerates to a constant-high output.
    function automatic logic [CNT_W-1:0] clamp_width(input logic [CNT_W-1:0] p,
                                                     input logic [CNT_W-1:0] w);
        return (w > p) ? p : w;
    endfunction

    state_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] per_r;
    logic [CNT_W-1:0] wid_r;
    logic             mode_r;
    logic             trig_d_r;
    logic             pulse_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;

    logic             trig_edge_s;
    logic             start_req_s;
    logic             per_zero_s;
    logic             boundary_s;
    logic [CNT_W-1:0] clamp_s;
    state_e           ld_state_s;
    logic [CNT_W-1:0] ld_cnt_s;
    logic             ld_pulse_s;

    // Start/boundary decode and the state a fresh continuous period loads into.
    always_comb begin
        trig_edge_s = trigger & ~trig_d_r;
        start_req_s = enable && (state_r == ST_IDLE) && ((mode == MODE_CONT) || trig_edge_s);
        per_zero_s  = (period == '0);
        clamp_s     = clamp_width(period, width);
        // A period ends when LOW expires, or when HIGH expires with no LOW phase.
        boundary_s  = (cnt_r == '0) &&
                      ((state_r == ST_LOW) ||
                       ((state_r == ST_HIGH) && (mode_r == MODE_CONT) && (per_r == wid_r)));
        ld_state_s  = ST_IDLE;
        ld_cnt_s    = '0;
        ld_pulse_s  = 1'b0;
        if (per_zero_s) begin
            ld_state_s = ST_IDLE;
            ld_cnt_s   = '0;
            ld_pulse_s = 1'b0;
        end else if (clamp_s != '0) begin
            ld_state_s = ST_HIGH;
            ld_cnt_s   = clamp_s - CNT_ONE;
            ld_pulse_s = 1'b1;
        end else begin
            // Zero width: skip HIGH and spend the whole period in LOW.
            ld_state_s = ST_LOW;
            ld_cnt_s   = period - CNT_ONE;
            ld_pulse_s = 1'b0;
        end
    end

    // Channel FSM with registered outputs; cnt_r holds remaining cycles minus one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            per_r    <= '0;
            wid_r    <= '0;
            mode_r   <= MODE_CONT;
            trig_d_r <= 1'b0;
            pulse_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            trig_d_r <= trigger;
            done_r   <= 1'b0;
            if (!enable) begin
                state_r <= ST_IDLE;
                cnt_r   <= '0;
                pulse_r <= 1'b0;
                busy_r  <= 1'b0;
            end else if (boundary_s) begin
                // Continuous re-latch: configuration changes apply from here.
                state_r <= ld_state_s;
                cnt_r   <= ld_cnt_s;
                pulse_r <= ld_pulse_s;
                busy_r  <= (ld_state_s != ST_IDLE);
                per_r   <= period;
                wid_r   <= clamp_s;
                if (per_zero_s) begin
                    err_r <= 1'b1;
                end else begin
                    err_r <= err_r;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start_req_s && per_zero_s) begin
                            err_r <= 1'b1;
                        end else if (start_req_s) begin
                            err_r  <= 1'b0;
                            mode_r <= mode;
                            per_r  <= period;
                            if (mode == MODE_CONT) begin
                                wid_r   <= clamp_s;
                                state_r <= ld_state_s;
                                cnt_r   <= ld_cnt_s;
                                pulse_r <= ld_pulse_s;
                                busy_r  <= 1'b1;
                            end else if (width == '0) begin
                                // Zero-length one-shot: report completion only.
                                wid_r  <= width;
                                done_r <= 1'b1;
                            end else begin
                                wid_r   <= width;
                                state_r <= ST_HIGH;
                                cnt_r   <= width - CNT_ONE;
                                pulse_r <= 1'b1;
                                busy_r  <= 1'b1;
                            end
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_HIGH: begin
                        if (cnt_r != '0) begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end else if (mode_r == MODE_ONESHOT) begin
                            state_r <= ST_IDLE;
                            pulse_r <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            // per_r > wid_r here; equality is handled as a boundary.
                            state_r <= ST_LOW;
                            cnt_r   <= per_r - wid_r - CNT_ONE;
                            pulse_r <= 1'b0;
                        end
                    end
                    ST_LOW: begin
                        if (cnt_r != '0) begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end else begin
                            cnt_r <= '0;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                        pulse_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pulse_out = pulse_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cfg_err   = err_r;

endmodule

// File: rtl/multi_pulse_gen.sv
// N-channel programmable pulse generator running on the 2x system clock.
//   sys_clk, sys_rst_n : clock and asynchronous active-low reset
//   enable/mode/trigger: per-channel control bits (NUM_CH wide)
//   period/width       : packed per-channel configuration, channel i at [i*CNT_W +: CNT_W]
//   pulse_out/busy/done/cfg_err : per-channel registered status and outputs
module multi_pulse_gen
    import multi_pulse_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH-1:0]       trigger,
    input  logic [NUM_CH*CNT_W-1:0] period,
    input  logic [NUM_CH*CNT_W-1:0] width,
    output logic [NUM_CH-1:0]       pulse_out,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       cfg_err
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulse_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (sys_clk),
            .rst_n     (sys_rst_n),
            .enable    (enable[i]),
            .mode      (mode[i]),
            .trigger   (trigger[i]),
            .period    (period[i*CNT_W +: CNT_W]),
            .width     (width[i*CNT_W +: CNT_W]),
            .pulse_out (pulse_out[i]),
            .busy      (busy[i]),
            .done      (done[i]),
            .cfg_err   (cfg_err[i])
        );
    end

endmodule

// File: doc/multi_pulse_gen.md
Name: multi_pulse_gen

Overview:
Parametrised N-channel pulse generator. It replaces the single fixed-rate pulse_signal block and runs on the doubled clock from clk_gen. Each channel has its own programmable period and width, and runs in either continuous (periodic) or one-shot (triggered) mode. Per-channel busy and done status allow a controller to sequence pulses.

Parameters:
NUM_CH, 4, number of independent pulse channels.
CNT_W, 16, width of the period/width fields and of the internal counters.

Ports:
sys_clk      input   1              system clock (the 2x clock from clk_gen).
sys_rst_n    input   1              asynchronous active-low reset.
enable       input   NUM_CH         per-channel run enable.
mode         input   NUM_CH         per channel: 0 = continuous, 1 = one-shot.
trigger      input   NUM_CH         per-channel one-shot trigger, rising-edge sensitive; synchronous to sys_clk.
period       input   NUM_CH*CNT_W   channel i in bits [i*CNT_W +: CNT_W]; total cycles per period.
width        input   NUM_CH*CNT_W   channel i in bits [i*CNT_W +: CNT_W]; high-time in cycles.
pulse_out    output  NUM_CH         registered pulse outputs.
busy         output  NUM_CH         channel is in HIGH or LOW state.
done         output  NUM_CH         one-cycle strobe at the end of a one-shot pulse.
cfg_err      output  NUM_CH         set when a start is attempted with period==0.

Behaviour:
- Reset (sys_rst_n low, asynchronous): all outputs 0, all channels IDLE, counters 0, trigger history 0. Release is synchronous to sys_clk.
- Per-channel FSM has three states:
  - IDLE: pulse_out=0, busy=0.
  - HIGH: pulse_out=1, busy=1.
  - LOW: pulse_out=0, busy=1.
- Configuration latch:
  - period/width are latched at start.
  - In continuous mode they are also re-latched at every period boundary.
  - Changes mid-period take effect at the next boundary. Inputs are never used live.
- Width clamp:
  - latched width > period is clamped to period, giving a constant-high output.
  - width == 0 gives HIGH a length of 0: the FSM goes straight to LOW and pulse_out stays 0 for the whole period.
- Continuous start:
  - On the edge where enable=1, mode=0 is sampled in IDLE, the FSM enters HIGH and pulse_out=1 from that edge.
  - HIGH lasts width cycles; LOW lasts period-width cycles.
  - Output repeats with exactly period cycles per cycle, no gap cycle between periods.
  - If period==width, LOW is skipped and the FSM re-enters HIGH.
- One-shot:
  - Start condition: enable=1, mode=1, in IDLE, trigger=1 and the previous-cycle trigger=0.
  - HIGH lasts width cycles, then the FSM returns to IDLE; period is ignored.
  - done=1 for exactly one cycle on the edge that leaves HIGH.
  - width==0 gives no pulse, and done strobes on the cycle after the trigger edge.
  - Triggers while busy are ignored; there is no queueing.
  - Trigger held high through reset release counts as an edge.
- period==0 at start: no start occurs, the channel stays IDLE, and cfg_err is set (sticky). cfg_err clears on the next successful start or on reset.
- Enable deassert in any state: on the next edge the FSM goes to IDLE, pulse_out=0, busy=0, and the counter clears. done is not asserted.
- Mode change while busy is ignored until the channel returns to IDLE.
- Counters are CNT_W bits, count down from the latched value, and never wrap. Maximum period is 2^CNT_W-1.
- Channels are fully independent; no cross-channel timing relation is required.

Decomposition:
- Shared package: FSM state encoding (ST_IDLE, ST_HIGH, ST_LOW) and mode constants (MODE_CONT=0, MODE_ONESHOT=1).
- Sub-module pulse_ch: one channel's FSM, counter, config latch and trigger edge detect, parametrised by CNT_W.
- multi_pulse_gen instantiates NUM_CH copies of pulse_ch via generate and slices the packed period/width buses.

Test Plan:
1. NUM_CH=4, CNT_W=16, ch0 continuous period=10 width=3, enable at cycle 5 -> pulse_out[0] high on cycles 5-7, low 8-14, high again at 15; period 10 sustained for 5 periods; busy[0]=1 throughout.
2. ch1 one-shot width=4, trigger rises at cycle 20 -> pulse_out[1] high on cycles 20-23; done[1]=1 only at cycle 24. A second trigger at 22 is ignored. A trigger at 30 gives a new 4-cycle pulse.
3. ch2 continuous period=8 width=2; change width to 5 mid-period -> current period keeps width 2, next period shows width 5, period stays 8.
4. Edge widths: width=0, period=6 -> pulse_out constantly 0, busy=1. width=9, period=6 -> constant 1. period=0 -> busy=0 and cfg_err=1, then period=4 -> cfg_err clears at start.
5. Deassert enable on ch0 mid-HIGH -> pulse_out and busy are 0 on the next edge, done stays 0. Re-enable -> a fresh full-width pulse.
6. Assert sys_rst_n=0 asynchronously mid-pulse on all channels -> all outputs 0 immediately. After release with enables held, all continuous channels restart on the first edge.
